// File: rtl/if_fetch.sv
// Instruction fetch: assembles a 32-bit little-endian instruction from four
// byte reads through a shared memory arbiter, then hands it to IF/ID.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  typedef enum logic [2:0] {
    ST_ISSUE0 = 3'd0,
    ST_ISSUE1 = 3'd1,
    ST_ISSUE2 = 3'd2,
    ST_ISSUE3 = 3'd3,
    ST_RECV   = 3'd4,
    ST_OUT    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        pending_q, pending_d;
  logic [1:0]  byte_q, byte_d;

  logic        flush;
  logic        issuing;
  logic [1:0]  issue_k;

  always_comb begin
    flush   = branch_flag_i && !stall_i;
    issuing = (state_q[2] == 1'b0);
    issue_k = state_q[1:0];

    mem_req_o  = issuing;
    mem_addr_o = pc_q + {30'd0, (issuing ? issue_k : 2'd0)};
    if_valid_o = (state_q == ST_OUT) && !flush && !rst;
    if_pc_o    = pc_q;
    if_inst_o  = inst_q;

    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    pending_d = 1'b0;
    byte_d    = byte_q;

    // The byte returned this cycle belongs to the lane granted last cycle.
    for (int i = 0; i < 4; i++) begin
      if (pending_q && (byte_q == 2'(i))) begin
        inst_d[8*i +: 8] = mem_rdata_i;
      end
    end

    case (state_q)
      ST_ISSUE0, ST_ISSUE1, ST_ISSUE2, ST_ISSUE3: begin
        if (mem_gnt_i) begin
          pending_d = 1'b1;
          byte_d    = issue_k;
          state_d   = (issue_k == 2'd3) ? ST_RECV : state_t'(state_q + 3'd1);
        end
      end
      ST_RECV: state_d = ST_OUT;
      ST_OUT: begin
        if (!stall_i) begin
          pc_d    = pc_q + 32'd4;
          state_d = ST_ISSUE0;
        end
      end
      default: state_d = ST_ISSUE0;
    endcase

    // A redirect wins over everything and drops the byte granted this cycle.
    if (flush) begin
      pc_d      = branch_target_i;
      state_d   = ST_ISSUE0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_ISSUE0;
      pc_q      <= RESET_PC;
      inst_q    <= 32'h0000_0013;
      pending_q <= 1'b0;
      byte_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      pending_q <= pending_d;
      byte_q    <= byte_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios with literal expectations plus a
// transaction-level fetch model checked every cycle.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_rdata_i = 8'hEE;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rdata_i     (mem_rdata_i),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .if_valid_o      (if_valid_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image: a real instruction at 0, a simple address hash elsewhere.
  function automatic logic [7:0] mb(input logic [31:0] a);
    if (a < 32'd4) begin
      case (a[1:0])
        2'd0:    return 8'h13;
        2'd1:    return 8'h05;
        2'd2:    return 8'h10;
        default: return 8'h00;
      endcase
    end
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {mb(pc + 32'd3), mb(pc + 32'd2), mb(pc + 32'd1), mb(pc)};
  endfunction

  // Arbiter/memory: the granted byte appears during the following cycle.
  always @(posedge clk)
    mem_rdata_i <= (mem_req_o && mem_gnt_i) ? mb(mem_addr_o) : 8'hEE;

  // Model: bytes granted for the current PC, then one capture cycle, then handoff.
  logic [31:0] exp_pc;
  int          exp_k;
  int          wait_c;
  bit          m_flush;
  bit          exp_v;

  always @(negedge clk) begin
    if (rst) begin
      chk("valid_in_reset", {31'd0, if_valid_o}, 32'd0);
      exp_pc = RESET_PC;
      exp_k  = 0;
      wait_c = 0;
    end else begin
      m_flush = branch_flag_i && !stall_i;
      chk("m_req", {31'd0, mem_req_o}, {31'd0, exp_k < 4});
      if (exp_k < 4) chk("m_addr", mem_addr_o, exp_pc + 32'(exp_k));
      exp_v = (exp_k == 4) && (wait_c == 1) && !m_flush;
      chk("m_valid", {31'd0, if_valid_o}, {31'd0, exp_v});
      if (exp_v) begin
        chk("m_pc", if_pc_o, exp_pc);
        chk("m_inst", if_inst_o, word_at(exp_pc));
      end
      if (m_flush) begin
        exp_pc = branch_target_i;
        exp_k  = 0;
        wait_c = 0;
      end else if (exp_k < 4) begin
        if (mem_gnt_i) exp_k++;
        wait_c = 0;
      end else if (wait_c == 0) begin
        wait_c = 1;
      end else if (!stall_i) begin
        exp_pc = exp_pc + 32'd4;
        exp_k  = 0;
        wait_c = 0;
      end
    end
  end

  // Advance one cycle and apply inputs shortly after the edge.
  task automatic cyc(input bit g, input bit s, input bit b, input logic [31:0] t);
    @(posedge clk);
    #1;
    mem_gnt_i       = g;
    stall_i         = s;
    branch_flag_i   = b;
    branch_target_i = t;
    #1;
  endtask

  initial begin
    rst = 1'b1; mem_gnt_i = 1'b1; stall_i = 1'b0;
    branch_flag_i = 1'b0; branch_target_i = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    // cycle 1: first request at RESET_PC, buffer holds the NOP
    chk("rst_req", {31'd0, mem_req_o}, 32'd1);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_valid", {31'd0, if_valid_o}, 32'd0);
    chk("rst_inst", if_inst_o, 32'h0000_0013);

    // basic fetch: valid in cycle 6
    repeat (5) cyc(1, 0, 0, 0);
    chk("basic_valid", {31'd0, if_valid_o}, 32'd1);
    chk("basic_inst", if_inst_o, 32'h0010_0513);
    chk("basic_pc", if_pc_o, 32'h0);
    cyc(1, 0, 0, 0);                                  // 7
    chk("basic_next_addr", mem_addr_o, 32'h4);

    // contention on byte 2
    cyc(1, 0, 0, 0);                                  // 8
    for (int i = 0; i < 3; i++) begin                 // 9..11
      cyc(0, 0, 0, 0);
      chk("cont_addr_hold", mem_addr_o, 32'h6);
    end
    cyc(1, 0, 0, 0);                                  // 12
    cyc(1, 0, 0, 0);                                  // 13
    cyc(1, 0, 0, 0);                                  // 14
    chk("cont_not_yet", {31'd0, if_valid_o}, 32'd0);

    // stall at handoff for 4 cycles
    cyc(1, 1, 0, 0);                                  // 15
    chk("cont_valid", {31'd0, if_valid_o}, 32'd1);
    chk("cont_inst", if_inst_o, 32'h5D5C_5F5E);
    for (int i = 0; i < 3; i++) begin                 // 16..18
      cyc(1, 1, 0, 0);
      chk("stall_valid", {31'd0, if_valid_o}, 32'd1);
      chk("stall_pc", if_pc_o, 32'h4);
      chk("stall_inst", if_inst_o, 32'h5D5C_5F5E);
    end
    cyc(1, 0, 0, 0);                                  // 19
    cyc(1, 0, 0, 0);                                  // 20
    chk("stall_next_addr", mem_addr_o, 32'h8);

    // branch in ISSUE(2)
    cyc(1, 0, 0, 0);                                  // 21
    cyc(1, 0, 1, 32'h100);                            // 22
    chk("br_issue2_addr", mem_addr_o, 32'hA);
    cyc(1, 0, 0, 0);                                  // 23
    chk("br_target_addr", mem_addr_o, 32'h100);
    repeat (4) cyc(1, 0, 0, 0);                       // 24..27
    cyc(1, 0, 0, 0);                                  // 28
    chk("br_valid", {31'd0, if_valid_o}, 32'd1);
    chk("br_pc", if_pc_o, 32'h100);

    // branch in OUT, first under stall (ignored), then taken
    repeat (5) cyc(1, 0, 0, 0);                       // 29..33
    cyc(1, 1, 1, 32'h200);                            // 34
    chk("brs_valid_held", {31'd0, if_valid_o}, 32'd1);
    chk("brs_pc", if_pc_o, 32'h104);
    cyc(1, 1, 1, 32'h200);                            // 35
    chk("brs_valid_held2", {31'd0, if_valid_o}, 32'd1);
    cyc(1, 0, 1, 32'h200);                            // 36
    chk("brs_flush_valid", {31'd0, if_valid_o}, 32'd0);
    cyc(1, 0, 0, 0);                                  // 37
    chk("brs_target_addr", mem_addr_o, 32'h200);

    // reset while in ISSUE(3)
    repeat (3) cyc(1, 0, 0, 0);                       // 38..40
    chk("rst3_addr", mem_addr_o, 32'h203);
    rst = 1'b1;
    #1;
    chk("rst3_valid", {31'd0, if_valid_o}, 32'd0);
    cyc(1, 0, 0, 0);                                  // 41
    rst = 1'b0;
    #1;
    chk("rst3_restart_addr", mem_addr_o, RESET_PC);
    chk("rst3_inst_nop", if_inst_o, 32'h0000_0013);
    repeat (5) cyc(1, 0, 0, 0);                       // 42..46
    chk("rst3_valid_out", {31'd0, if_valid_o}, 32'd1);
    chk("rst3_inst", if_inst_o, 32'h0010_0513);

    // unaligned redirect is taken as-is
    cyc(1, 0, 1, 32'h301);                            // 47
    cyc(1, 0, 0, 0);                                  // 48
    chk("unal_addr", mem_addr_o, 32'h301);
    repeat (4) cyc(1, 0, 0, 0);                       // 49..52
    cyc(1, 0, 0, 0);                                  // 53
    chk("unal_pc", if_pc_o, 32'h301);
    chk("unal_inst", if_inst_o, 32'h5D5A_5B58);

    // mixed grant/stall/branch traffic, checked by the model
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 12) == 0, $urandom);
    end
    cyc(1, 0, 0, 0);
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
